// File: rtl/hv_spatial_encoder_pkg.sv
// Shared types and helpers for the hypervector spatial encoder.
package hv_spatial_encoder_pkg;

  // Default channel counts per modality
  localparam int GSR_NUM_CHANNEL = 2;
  localparam int ECG_NUM_CHANNEL = 3;
  localparam int EEG_NUM_CHANNEL = 32;

  // Encoder state; the three ACC states bundle one modality each
  typedef enum logic [1:0] {
    ACC_GSR = 2'd0,
    ACC_ECG = 2'd1,
    ACC_EEG = 2'd2,
    OUT     = 2'd3
  } state_e;

  // Ceiling log2, never below 1 so widths stay legal
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << r) < v) r = i + 1;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bitwise 3-input majority
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/hv_spatial_encoder_if.sv
// Slice-in / fused-slice-out handshake bundle of the spatial encoder.
interface hv_spatial_encoder_if #(
  parameter int FOLD_WIDTH      = 2000,
  parameter int NUM_FOLDS_WIDTH = 1
);
  import hv_spatial_encoder_pkg::*;

  logic                       fin_valid;
  logic                       fin_ready;
  logic [FOLD_WIDTH-1:0]      im_in;
  logic [FOLD_WIDTH-1:0]      projm_in;
  logic                       dout_valid;
  logic                       dout_ready;
  logic [FOLD_WIDTH-1:0]      hv_out;
  logic [NUM_FOLDS_WIDTH-1:0] fold_idx;
  logic [1:0]                 class_idx;
  logic                       dout_last;

  // Encoder side
  modport slave (
    input  fin_valid, im_in, projm_in, dout_ready,
    output fin_ready, dout_valid, hv_out, fold_idx, class_idx, dout_last
  );

  // Upstream generator / downstream AM side
  modport master (
    output fin_valid, im_in, projm_in, dout_ready,
    input  fin_ready, dout_valid, hv_out, fold_idx, class_idx, dout_last
  );

endinterface

// File: rtl/hv_bit_accumulator.sv
// One bundling counter for a single hypervector bit, with majority compare.
module hv_bit_accumulator
  import hv_spatial_encoder_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add,
  input  logic             bit_in,
  input  logic [CNT_W-1:0] n,
  output logic             maj
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   sum;

  // Count set bound bits; clear wins so the final beat restarts at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (add) cnt <= cnt + CNT_W'(bit_in);
  end

  // Majority includes the current beat; a tie resolves to 0
  always_comb begin
    sum = {1'b0, cnt} + (CNT_W+1)'(bit_in);
    maj = {sum, 1'b0} > {2'b00, n};
  end

endmodule

// File: rtl/hv_spatial_encoder.sv
// Binds im^projm per channel, bundles GSR/ECG/EEG by majority and fuses
// the three modality slices with a 3-input majority.
module hv_spatial_encoder
  import hv_spatial_encoder_pkg::*;
#(
  parameter int NUM_FOLDS       = 1,
  parameter int NUM_FOLDS_WIDTH = 1,
  parameter int FOLD_WIDTH      = 2000,
  parameter int GSR_CH          = GSR_NUM_CHANNEL,
  parameter int ECG_CH          = ECG_NUM_CHANNEL,
  parameter int EEG_CH          = EEG_NUM_CHANNEL
) (
  input  logic                 clk,
  input  logic                 rst,
  hv_spatial_encoder_if.slave  bus
);

  localparam int CNT_W = clog2(max3(GSR_CH, ECG_CH, EEG_CH) + 1);
  localparam logic [NUM_FOLDS_WIDTH-1:0] FOLD_RST = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

  state_e state_q, state_d;

  logic                       fin_ready, dout_valid, dout_last;
  logic                       fin_fire, dout_fire, last_beat;
  logic [CNT_W-1:0]           n_cur, chan_cnt;
  logic [FOLD_WIDTH-1:0]      bound, maj_vec, fused;
  logic [FOLD_WIDTH-1:0]      gsr_hv, ecg_hv, hv_out_q;
  logic [NUM_FOLDS_WIDTH-1:0] fold_q;
  logic [1:0]                 class_q;

  assign fin_fire  = bus.fin_valid & fin_ready;
  assign dout_fire = dout_valid & bus.dout_ready;
  assign bound     = bus.im_in ^ bus.projm_in;
  assign last_beat = fin_fire && (chan_cnt == n_cur - CNT_W'(1));

  // Channel count of the modality being bundled
  always_comb begin
    n_cur = CNT_W'(GSR_CH);
    case (state_q)
      ACC_ECG: n_cur = CNT_W'(ECG_CH);
      ACC_EEG: n_cur = CNT_W'(EEG_CH);
      default: n_cur = CNT_W'(GSR_CH);
    endcase
  end

  // Per-bit bundling counters, shared by all three modalities
  hv_bit_accumulator #(.CNT_W(CNT_W)) u_acc [FOLD_WIDTH-1:0] (
    .clk    (clk),
    .rst    (rst),
    .clr    (last_beat),
    .add    (fin_fire),
    .bit_in (bound),
    .n      (n_cur),
    .maj    (maj_vec)
  );

  // EEG majority is taken straight from the counters on its final beat
  for (genvar b = 0; b < FOLD_WIDTH; b++) begin : g_fuse
    assign fused[b] = maj3(gsr_hv[b], ecg_hv[b], maj_vec[b]);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACC_GSR;
    else     state_q <= state_d;
  end

  // Next state: advance modality on its last channel, leave OUT on handoff
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC_GSR: if (last_beat) state_d = ACC_ECG;
      ACC_ECG: if (last_beat) state_d = ACC_EEG;
      ACC_EEG: if (last_beat) state_d = OUT;
      OUT:     if (dout_fire) state_d = ACC_GSR;
      default: state_d = ACC_GSR;
    endcase
  end

  // Outputs decoded from state; upstream stalls while a slice is pending
  always_comb begin
    fin_ready  = (state_q != OUT);
    dout_valid = (state_q == OUT);
    dout_last  = dout_valid && (fold_q == '0) && (class_q == 2'd2);
  end

  // Channel counter and modality slice latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_cnt <= '0;
      gsr_hv   <= '0;
      ecg_hv   <= '0;
      hv_out_q <= '0;
    end else begin
      if (fin_fire) chan_cnt <= last_beat ? '0 : chan_cnt + CNT_W'(1);
      if (last_beat) begin
        case (state_q)
          ACC_GSR: gsr_hv   <= maj_vec;
          ACC_ECG: ecg_hv   <= maj_vec;
          ACC_EEG: hv_out_q <= fused;
          default: ;
        endcase
      end
    end
  end

  // Slice indices: class cycles 0..2, fold counts down and wraps per set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fold_q  <= FOLD_RST;
      class_q <= '0;
    end else if (dout_fire) begin
      if (class_q == 2'd2) begin
        class_q <= '0;
        fold_q  <= (fold_q == '0) ? FOLD_RST : fold_q - NUM_FOLDS_WIDTH'(1);
      end else begin
        class_q <= class_q + 2'd1;
      end
    end
  end

  assign bus.fin_ready  = fin_ready;
  assign bus.dout_valid = dout_valid;
  assign bus.dout_last  = dout_last;
  assign bus.hv_out     = hv_out_q;
  assign bus.fold_idx   = fold_q;
  assign bus.class_idx  = class_q;

  // Channel counter must stay below the active modality's count
  chan_bound_a: assert property (@(posedge clk) disable iff (rst)
    (state_q != OUT) |-> (chan_cnt < n_cur));

endmodule

// File: tb/tb_hv_spatial_encoder.sv
// Directed bench: two encoders (1 fold and 2 folds) share one stimulus.
module tb_hv_spatial_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fin_valid = 1'b0;
  logic       dout_ready = 1'b0;
  logic [7:0] im_in = '0;
  logic [7:0] projm_in = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hv_spatial_encoder_if #(.FOLD_WIDTH(8), .NUM_FOLDS_WIDTH(1)) b1 ();
  hv_spatial_encoder_if #(.FOLD_WIDTH(8), .NUM_FOLDS_WIDTH(1)) b2 ();

  assign b1.fin_valid  = fin_valid;
  assign b1.im_in      = im_in;
  assign b1.projm_in   = projm_in;
  assign b1.dout_ready = dout_ready;
  assign b2.fin_valid  = fin_valid;
  assign b2.im_in      = im_in;
  assign b2.projm_in   = projm_in;
  assign b2.dout_ready = dout_ready;

  hv_spatial_encoder #(.NUM_FOLDS(1), .NUM_FOLDS_WIDTH(1), .FOLD_WIDTH(8),
    .GSR_CH(3), .ECG_CH(4), .EEG_CH(5)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  hv_spatial_encoder #(.NUM_FOLDS(2), .NUM_FOLDS_WIDTH(1), .FOLD_WIDTH(8),
    .GSR_CH(3), .ECG_CH(4), .EEG_CH(5)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present n beats of one channel pattern; every beat must be accepted
  task automatic feed(input logic [7:0] im, input logic [7:0] pm, input int n);
    for (int i = 0; i < n; i++) begin
      fin_valid = 1'b1;
      im_in     = im;
      projm_in  = pm;
      @(negedge clk);
      chk("fin_ready", b1.fin_ready, 1);
      chk("early_valid", b1.dout_valid, 0);
      @(posedge clk); #1;
    end
    fin_valid = 1'b0;
  endtask

  // Check the pending slice on both encoders (dut1 fold is always 0)
  task automatic slice_chk(input logic [7:0] hv, input logic [1:0] cls,
                           input logic f2, input logic last1, input logic last2);
    @(negedge clk);
    chk("d1_valid", b1.dout_valid, 1);
    chk("d1_hv", b1.hv_out, hv);
    chk("d1_class", b1.class_idx, cls);
    chk("d1_fold", b1.fold_idx, 0);
    chk("d1_last", b1.dout_last, last1);
    chk("d2_valid", b2.dout_valid, 1);
    chk("d2_hv", b2.hv_out, hv);
    chk("d2_class", b2.class_idx, cls);
    chk("d2_fold", b2.fold_idx, f2);
    chk("d2_last", b2.dout_last, last2);
    chk("out_stall", b1.fin_ready, 0);
  endtask

  // Hand the slice downstream in a single cycle
  task automatic accept();
    dout_ready = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b0;
    chk("post_accept_valid", b1.dout_valid, 0);
    chk("post_accept_ready", b1.fin_ready, 1);
  endtask

  task automatic ones_set();
    feed(8'hFF, 8'h00, 12);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fin_ready", b1.fin_ready, 1);
    chk("rst_valid", b1.dout_valid, 0);
    chk("rst_hv", b1.hv_out, 0);
    chk("rst_class", b1.class_idx, 0);
    chk("rst_last", b1.dout_last, 0);
    chk("rst_fold1", b1.fold_idx, 0);
    chk("rst_fold2", b2.fold_idx, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Slice 1: all-ones bind, valid appears right after the 12th beat
    ones_set();
    slice_chk(8'hFF, 2'd0, 1'b1, 1'b0, 1'b0);

    // Backpressure: offered input is refused, output held
    fin_valid = 1'b1; im_in = 8'hAA; projm_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_fin_ready", b1.fin_ready, 0);
      chk("bp_valid", b1.dout_valid, 1);
      chk("bp_hv", b1.hv_out, 8'hFF);
      chk("bp_class", b1.class_idx, 0);
      @(posedge clk); #1;
    end
    fin_valid = 1'b0;
    accept();

    // Slice 2: ECG tie -> 0; fused maj3(0F,00,F0)=00
    feed(8'h3C, 8'h33, 3);
    feed(8'hF0, 8'h00, 2);
    feed(8'h5A, 8'h5A, 2);
    feed(8'h0F, 8'hFF, 5);
    slice_chk(8'h00, 2'd1, 1'b1, 1'b0, 1'b0);
    accept();

    // Slice 3: GSR 2/3 -> 0F, ECG 3/4 -> F0, EEG 3/5 on 3C (2/5 on C3) -> 3C
    feed(8'h0F, 8'h00, 2);
    feed(8'h00, 8'h00, 1);
    feed(8'hF0, 8'h00, 3);
    feed(8'h00, 8'h00, 1);
    feed(8'h3C, 8'h00, 3);
    feed(8'hC3, 8'h00, 2);
    slice_chk(8'h3C, 2'd2, 1'b1, 1'b1, 1'b0);
    accept();

    // Slices 4..7: fold sequencing on the two-fold encoder
    ones_set();
    slice_chk(8'hFF, 2'd0, 1'b0, 1'b0, 1'b0);
    accept();
    ones_set();
    slice_chk(8'hFF, 2'd1, 1'b0, 1'b0, 1'b0);
    accept();
    ones_set();
    slice_chk(8'hFF, 2'd2, 1'b0, 1'b1, 1'b1);
    accept();
    ones_set();
    slice_chk(8'hFF, 2'd0, 1'b1, 1'b0, 1'b0);
    accept();

    // Async reset after 2 EEG beats
    feed(8'h00, 8'h00, 3);
    feed(8'h00, 8'h00, 4);
    feed(8'hFF, 8'h00, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_fin_ready", b1.fin_ready, 1);
    chk("arst_valid", b1.dout_valid, 0);
    chk("arst_hv", b1.hv_out, 0);
    chk("arst_class", b2.class_idx, 0);
    chk("arst_fold2", b2.fold_idx, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    ones_set();
    slice_chk(8'hFF, 2'd0, 1'b1, 1'b0, 1'b0);
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hv_spatial_encoder.md
Name: hv_spatial_encoder

Overview:
- Consumes the folded (im, projm) hypervector slice stream from the HV generator.
- Binds each channel's slice as im XOR projm and bundles per modality (GSR, ECG, EEG) with per-bit counters and a majority threshold.
- Fuses the three modality slices with a bitwise 3-input majority and emits one fused FOLD_WIDTH slice per (fold, classification) to the downstream associative-memory stage.

Parameters:
- NUM_FOLDS, 1, number of folds per classification set; 1 = unfolded
- NUM_FOLDS_WIDTH, 1, ceillog(NUM_FOLDS), minimum 1
- FOLD_WIDTH, 2000, slice width; must be a factor of HV_DIMENSION
- GSR_CH, `GSR_NUM_CHANNEL, GSR channels per classification
- ECG_CH, `ECG_NUM_CHANNEL, ECG channels per classification
- EEG_CH, `EEG_NUM_CHANNEL, EEG channels per classification

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fin_valid  in  1  input slice valid
- fin_ready  out  1  block accepts input slice
- im_in  in  FOLD_WIDTH  item-memory slice for the current channel
- projm_in  in  FOLD_WIDTH  projection slice for the current channel
- dout_valid  out  1  fused slice valid
- dout_ready  in  1  downstream accepts
- hv_out  out  FOLD_WIDTH  fused query slice
- fold_idx  out  NUM_FOLDS_WIDTH  fold of hv_out; counts NUM_FOLDS-1 down to 0
- class_idx  out  2  classification 0..2 of hv_out
- dout_last  out  1  high with the final slice of a set (fold_idx==0, class_idx==2)

Behaviour:
- Reset (async, any state): state=ACC_GSR, all per-bit counters=0, chan_cnt=0, fold_idx=NUM_FOLDS-1, class_idx=0, hv_out=0, dout_valid=0, dout_last=0, gsr_hv=0, ecg_hv=0. fin_ready is combinational from state.
- States: ACC_GSR, ACC_ECG, ACC_EEG, OUT.
- fin_ready=1 in the three ACC states and 0 in OUT. dout_valid=1 only in OUT.
- Fire: fin_fire = fin_valid & fin_ready; dout_fire = dout_valid & dout_ready.
- On each fin_fire, bound = im_in ^ projm_in. Per bit b, cnt[b] <= cnt[b] + bound[b]. Counter width = clog2(max(GSR_CH, ECG_CH, EEG_CH)+1). chan_cnt increments.
- Majority rule: bit=1 iff 2*(cnt[b]+bound[b]) > N, where N is the modality's channel count. A tie gives 0. The current beat's bound bit is included in the final evaluation.
- On the fin_fire where chan_cnt==N-1:
  - ACC_GSR: latch gsr_hv, clear cnt and chan_cnt, go to ACC_ECG.
  - ACC_ECG: latch ecg_hv, clear cnt and chan_cnt, go to ACC_EEG.
  - ACC_EEG: hv_out <= maj3(gsr_hv, ecg_hv, eeg_maj), clear cnt and chan_cnt, go to OUT.
- OUT: hv_out, fold_idx, class_idx and dout_last are held stable while dout_ready=0. On dout_fire, go to ACC_GSR and advance the indices:
  - class_idx < 2: class_idx++.
  - class_idx == 2: class_idx=0; fold_idx-- if nonzero, else fold_idx=NUM_FOLDS-1 (wrap to the next set).
- Latency: dout_valid rises 1 cycle after the last EEG fin_fire. Throughput: GSR_CH+ECG_CH+EEG_CH+1 cycles per slice with dout_ready held high.
- No input is accepted during OUT; upstream stalls via fin_ready=0.
- A zero projm slice contributes im_in unchanged. Upstream is responsible for channel masking.
- Counters cannot overflow by construction; an assertion checks chan_cnt < N.

Decomposition:
- Shared package / const.vh holds:
  - state encoding localparams
  - modality channel-count defaults
  - a maj3 function
  - a clog2 helper for counter width
- One natural sub-module: hv_bit_accumulator.
  - One per-bit counter with clear, add and threshold-compare outputs.
  - Generated FOLD_WIDTH times.
  - Parameterised by counter width.

Test Plan:
- Config for all scenarios: FOLD_WIDTH=8, GSR_CH=3, ECG_CH=4, EEG_CH=5, NUM_FOLDS=1.
- All-ones bind: feed im_in=8'hFF, projm_in=8'h00 for 12 beats -> hv_out=8'hFF, class_idx=0, dout_valid 1 cycle after the 12th fire.
- ECG tie: GSR bound=8'h0F on all 3 beats; ECG bound=8'hF0 on 2 beats and 8'h00 on 2; EEG bound=8'hF0 on all 5 -> ecg_hv=8'h00 (tie -> 0), hv_out=maj3(0F,00,F0)=8'h00.
- Backpressure: hold dout_ready=0 for 5 cycles in OUT -> hv_out stable, fin_ready=0, no input beats consumed; release -> next set starts accumulating.
- Set sequencing, NUM_FOLDS=2: run 6 slices -> (fold_idx, class_idx) = (1,0),(1,1),(1,2),(0,0),(0,1),(0,2); dout_last only on the 6th; the 7th slice is (1,0).
- Async reset mid-operation: assert rst after 2 EEG beats -> immediate return to ACC_GSR with counters cleared; a full 12-beat all-ones stream then yields 8'hFF with fold_idx=NUM_FOLDS-1, class_idx=0.
